// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN datapath blocks.
// Width functions keep the MAC tree and its consumers in agreement.
package cnn_pkg;

  localparam int unsigned KERNEL_SIZE_DEF = 3;
  localparam int unsigned WINDOW_PIXELS   = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;

  function automatic int unsigned prod_width(input int unsigned data_w, input int unsigned weight_w);
    return data_w + weight_w + 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned n, input int unsigned data_w,
                                            input int unsigned weight_w);
    return prod_width(data_w, weight_w) + $clog2(n);
  endfunction

  // Clip a wide signed value into the signed range of a w-bit result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Two-stage signed MAC: registered per-pixel products, then a registered sum.
// Pixels are unsigned and zero-extended; weights are two's complement.
module mac_adder_tree
  import cnn_pkg::*;
#(
  parameter int unsigned N           = WINDOW_PIXELS,
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned WEIGHT_SIZE = 8
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic [N*DATA_SIZE-1:0]                                pixels,
  input  logic [N*WEIGHT_SIZE-1:0]                              weights,
  output logic signed [sum_width(N, DATA_SIZE, WEIGHT_SIZE)-1:0] sum
);

  localparam int unsigned PW = prod_width(DATA_SIZE, WEIGHT_SIZE);
  localparam int unsigned SW = sum_width(N, DATA_SIZE, WEIGHT_SIZE);

  logic signed [PW-1:0] prod [N];
  logic signed [SW-1:0] sum_c;

  // Sign-extend every product before accumulation; SW bits cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_c = sum_c + SW'(prod[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        prod[i] <= '0;
      end
      sum <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        prod[i] <= PW'($signed({1'b0, pixels[i*DATA_SIZE +: DATA_SIZE]}))
                 * PW'($signed(weights[i*WEIGHT_SIZE +: WEIGHT_SIZE]));
      end
      sum <= sum_c;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Window convolution stage: drops row-straddling windows, runs a KxK signed
// dot product plus bias, optional ReLU and saturation, with frame tracking.
module conv_window_mac
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned WEIGHT_SIZE = 8,
  parameter int unsigned ROW_SIZE    = 28,
  parameter int unsigned COLUMN_SIZE = 28,
  parameter int unsigned OUT_SIZE    = 16
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]      window_in,
  input  logic                                              window_valid,
  input  logic [WEIGHT_SIZE-1:0]                            weight_in,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]        weight_addr,
  input  logic                                              weight_wr_en,
  input  logic [OUT_SIZE-1:0]                               bias_in,
  input  logic                                              bias_wr_en,
  input  logic                                              relu_en,
  output logic [OUT_SIZE-1:0]                               conv_out,
  output logic                                              conv_valid,
  output logic                                              frame_done
);

  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned SW = sum_width(KK, DATA_SIZE, WEIGHT_SIZE);
  localparam int unsigned RW = $clog2(COLUMN_SIZE);
  localparam int unsigned CW = $clog2(ROW_SIZE);

  logic [KK*WEIGHT_SIZE-1:0] weights;
  logic signed [OUT_SIZE-1:0] bias;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic keep_c, last_c;
  logic v1, v2, l1, l2;
  logic signed [SW-1:0] sum;
  logic signed [63:0] total_c;
  logic [OUT_SIZE-1:0] result_c;

  // Coefficient registers; out-of-range addresses are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      weights <= '0;
      bias    <= '0;
    end else begin
      if (weight_wr_en && (32'(weight_addr) < KK)) begin
        weights[32'(weight_addr)*WEIGHT_SIZE +: WEIGHT_SIZE] <= weight_in;
      end
      if (bias_wr_en) begin
        bias <= bias_in;
      end
    end
  end

  // Position of the newest pixel in the incoming window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= RW'(KERNEL_SIZE - 1);
      col <= CW'(KERNEL_SIZE - 1);
    end else if (window_valid) begin
      if (col == CW'(ROW_SIZE - 1)) begin
        if (row == RW'(COLUMN_SIZE - 1)) begin
          row <= RW'(KERNEL_SIZE - 1);
          col <= CW'(KERNEL_SIZE - 1);
        end else begin
          row <= row + RW'(1);
          col <= '0;
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_comb begin
    keep_c = window_valid && (col >= CW'(KERNEL_SIZE - 1));
    last_c = keep_c && (row == RW'(COLUMN_SIZE - 1)) && (col == CW'(ROW_SIZE - 1));
  end

  mac_adder_tree #(
    .N           (KK),
    .DATA_SIZE   (DATA_SIZE),
    .WEIGHT_SIZE (WEIGHT_SIZE)
  ) u_mac (
    .clock   (clock),
    .reset   (reset),
    .pixels  (window_in),
    .weights (weights),
    .sum     (sum)
  );

  // S3: bias, optional ReLU, then clip to the output range.
  always_comb begin
    total_c = 64'(sum) + 64'(bias);
    if (relu_en && (total_c < 64'sd0)) begin
      result_c = '0;
    end else begin
      result_c = OUT_SIZE'(saturate(total_c, OUT_SIZE));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1         <= 1'b0;
      l1         <= 1'b0;
      v2         <= 1'b0;
      l2         <= 1'b0;
      conv_valid <= 1'b0;
      frame_done <= 1'b0;
      conv_out   <= '0;
    end else begin
      v1         <= keep_c;
      l1         <= last_c;
      v2         <= v1;
      l2         <= l1;
      conv_valid <= v2;
      frame_done <= l2;
      if (v2) begin
        conv_out <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: ramp frames, drop rule, saturation,
// ReLU, weight-write timing, bias and mid-frame reset.
module tb_conv_window_mac;

  localparam int K  = 3;
  localparam int WB = K * K * 8;

  logic          clock;
  logic          reset;
  logic [WB-1:0] window_in;
  logic          window_valid;
  logic [7:0]    weight_in;
  logic [3:0]    weight_addr;
  logic          weight_wr_en;
  logic [15:0]   bias_in;
  logic          bias_wr_en;
  logic          relu_en;
  logic [15:0]   conv_out;
  logic          conv_valid;
  logic          frame_done;

  conv_window_mac dut (
    .clock        (clock),
    .reset        (reset),
    .window_in    (window_in),
    .window_valid (window_valid),
    .weight_in    (weight_in),
    .weight_addr  (weight_addr),
    .weight_wr_en (weight_wr_en),
    .bias_in      (bias_in),
    .bias_wr_en   (bias_wr_en),
    .relu_en      (relu_en),
    .conv_out     (conv_out),
    .conv_valid   (conv_valid),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int brow = 2, bcol = 2;
  int cyc = 0, first_cyc = -1, pulses = 0, dones = 0, done_at = -1;
  logic hv [3];
  logic hl [3];
  int   hval [3];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0; hl[i] = 1'b0; hval[i] = 0;
    end
  endtask

  // One clock: present a window, advance the expected position, check the output 3 cycles later.
  task automatic tick(input logic v, input logic [WB-1:0] w, input int ev);
    logic keep, last;
    window_valid = v;
    window_in    = w;
    keep = v && (bcol >= K - 1);
    last = keep && (brow == 27) && (bcol == 27);
    if (v) begin
      if (bcol == 27) begin
        if (brow == 27) begin brow = 2; bcol = 2; end
        else begin brow++; bcol = 0; end
      end else bcol++;
    end
    @(posedge clock); #1;
    window_valid = 1'b0;
    weight_wr_en = 1'b0;
    bias_wr_en   = 1'b0;
    cyc++;
    hv[2] = hv[1]; hl[2] = hl[1]; hval[2] = hval[1];
    hv[1] = hv[0]; hl[1] = hl[0]; hval[1] = hval[0];
    hv[0] = keep;  hl[0] = last;  hval[0] = ev;
    check("conv_valid", 32'(conv_valid), 32'(hv[2]));
    check("frame_done", 32'(frame_done), 32'(hl[2]));
    if (hv[2]) check("conv_out", 32'($signed(conv_out)), hval[2]);
    if (conv_valid) begin
      pulses++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (frame_done) begin
      dones++;
      done_at = pulses;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 0);
  endtask

  task automatic write_weight(input int addr, input logic [7:0] val);
    weight_addr  = 4'(addr);
    weight_in    = val;
    weight_wr_en = 1'b1;
    tick(1'b0, '0, 0);
  endtask

  task automatic write_all(input logic [7:0] val);
    for (int i = 0; i < K * K; i++) write_weight(i, val);
  endtask

  task automatic write_bias(input logic [15:0] val);
    bias_in    = val;
    bias_wr_en = 1'b1;
    tick(1'b0, '0, 0);
  endtask

  function automatic logic [WB-1:0] make_ramp(input int r0, input int c0);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*8 +: 8] = 8'((r0 - 2 + r) + (c0 - 2 + c));
    return w;
  endfunction

  function automatic logic [WB-1:0] win_fill(input logic [7:0] other, input logic [7:0] centre);
    logic [WB-1:0] w;
    for (int i = 0; i < K * K; i++) w[i*8 +: 8] = (i == 4) ? centre : other;
    return w;
  endfunction

  // With all weights 1 the ramp window sum is 9 * (row + col - 2).
  task automatic run_ramp(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, make_ramp(brow, bcol), 9 * (brow + bcol - 2));
  endtask

  initial begin
    reset = 1'b1; window_in = '0; window_valid = 1'b0; weight_in = '0; weight_addr = '0;
    weight_wr_en = 1'b0; bias_in = '0; bias_wr_en = 1'b0; relu_en = 1'b0;
    clear_hist();
    repeat (2) @(posedge clock);
    #1;
    check("reset_conv_out", 32'(conv_out), 0);
    check("reset_conv_valid", 32'(conv_valid), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    reset = 1'b0;

    // Ramp frame with unit weights: latency, pulse count, frame_done placement.
    write_all(8'd1);
    cyc = 0; first_cyc = -1; pulses = 0; dones = 0; done_at = -1;
    run_ramp(726);
    idle(4);
    check("first_latency", first_cyc, 3);
    check("frame_pulses", pulses, 676);
    check("frame_dones", dones, 1);
    check("frame_done_at", done_at, 676);

    // Saturation high, low, and ReLU on the negative case.
    write_all(8'd127);
    tick(1'b1, win_fill(8'd255, 8'd255), 32767);
    idle(3);
    write_all(8'h80);
    tick(1'b1, win_fill(8'd255, 8'd255), -32768);
    idle(3);
    relu_en = 1'b1;
    tick(1'b1, win_fill(8'd255, 8'd255), 0);
    idle(3);
    relu_en = 1'b0;

    // Negative bias with centre weight only.
    write_all(8'd0);
    write_weight(4, 8'd1);
    write_bias(-16'sd10);
    tick(1'b1, win_fill(8'd200, 8'd7), -3);
    idle(3);
    relu_en = 1'b1;
    tick(1'b1, win_fill(8'd200, 8'd7), 0);
    idle(3);
    relu_en = 1'b0;
    write_bias(16'd0);

    // Weight write on the same edge as a kept window, then an out-of-range write.
    write_weight(4, 8'd2);
    weight_addr = 4'd4; weight_in = 8'd5; weight_wr_en = 1'b1;
    tick(1'b1, win_fill(8'd99, 8'd10), 20);
    tick(1'b1, win_fill(8'd99, 8'd10), 50);
    weight_addr = 4'd9; weight_in = 8'd77; weight_wr_en = 1'b1;
    tick(1'b1, win_fill(8'd99, 8'd10), 50);
    tick(1'b1, win_fill(8'd99, 8'd10), 50);
    idle(3);

    // Mid-frame reset: pipeline flushes silently, next frame is complete.
    write_all(8'd1);
    run_ramp(100);
    reset = 1'b1;
    clear_hist();
    brow = 2; bcol = 2;
    #1;
    check("midreset_conv_valid", 32'(conv_valid), 0);
    check("midreset_conv_out", 32'(conv_out), 0);
    tick(1'b0, '0, 0);
    reset = 1'b0;
    pulses = 0; dones = 0;
    idle(4);
    check("flush_pulses", pulses, 0);
    write_all(8'd1);
    pulses = 0; dones = 0; done_at = -1;
    run_ramp(726);
    idle(4);
    check("frame2_pulses", pulses, 676);
    check("frame2_dones", dones, 1);
    check("frame2_done_at", done_at, 676);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
